// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory stage: FSM encoding, MEM/WB
// register layout and the byte-address to word-offset helper.
package mem_stage_pkg;

  localparam int          DATA_W            = 32;
  localparam int          REG_ADDR_W        = 4;
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;
  localparam int          CNT_W             = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  typedef struct packed {
    logic                  wb_en;
    logic                  mem_r_en;
    logic [DATA_W-1:0]     alu_res;
    logic [DATA_W-1:0]     mem_data;
    logic [REG_ADDR_W-1:0] dest;
  } memwb_t;

  // Unsigned 32-bit distance from the base, in words (low two bits dropped).
  function automatic logic [DATA_W-1:0] word_offset(input logic [DATA_W-1:0] addr,
                                                    input logic [DATA_W-1:0] base);
    logic [DATA_W-1:0] diff;
    diff = addr - base;
    return {2'b00, diff[DATA_W-1:2]};
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Execute-to-memory bus and MEM/WB outputs of the memory stage.
// master = upstream/write-back side, slave = mem_stage.
interface mem_stage_if
  import mem_stage_pkg::*;
();

  logic                  WB_EN;
  logic                  MEM_R_EN;
  logic                  MEM_W_EN;
  logic [DATA_W-1:0]     ALU_Res;
  logic [DATA_W-1:0]     Val_Rm;
  logic [REG_ADDR_W-1:0] Dest;

  logic                  freeze;
  logic                  WB_EN_out;
  logic                  MEM_R_EN_out;
  logic [DATA_W-1:0]     ALU_Res_out;
  logic [DATA_W-1:0]     Mem_Data_out;
  logic [REG_ADDR_W-1:0] Dest_out;

  modport master (
    output WB_EN, MEM_R_EN, MEM_W_EN, ALU_Res, Val_Rm, Dest,
    input  freeze, WB_EN_out, MEM_R_EN_out, ALU_Res_out, Mem_Data_out, Dest_out
  );

  modport slave (
    input  WB_EN, MEM_R_EN, MEM_W_EN, ALU_Res, Val_Rm, Dest,
    output freeze, WB_EN_out, MEM_R_EN_out, ALU_Res_out, Mem_Data_out, Dest_out
  );

endinterface

// File: rtl/mem_stage_data_memory.sv
// DEPTH x 32 word memory mapped at BASE_ADDR: asynchronous read, synchronous
// write gated by enable and by the in-range flag it reports.
module data_memory
  import mem_stage_pkg::*;
#(
  parameter int                DEPTH     = 64,
  parameter logic [DATA_W-1:0] BASE_ADDR = DEFAULT_BASE_ADDR
) (
  input  logic              clk,
  input  logic              i_en,
  input  logic              i_we,
  input  logic [DATA_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_in_range
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] w_off;
  logic [IDX_W-1:0]  w_idx;

  assign w_off      = word_offset(i_addr, BASE_ADDR);
  assign w_idx      = w_off[IDX_W-1:0];
  assign o_in_range = (i_addr >= BASE_ADDR) && (w_off < DATA_W'(DEPTH));
  assign o_rdata    = o_in_range ? r_mem[w_idx] : '0;

  // NOTE: the array has no reset; contents survive reset and it can map onto RAM.
  always_ff @(posedge clk) begin
    if (i_en && i_we && o_in_range) begin
      r_mem[w_idx] <= i_wdata;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: multi-cycle load/store FSM with upstream freeze and the MEM/WB
// register. Optional MEM_STAGE_BOUNDS_CHK_EN adds a sticky mem_err output.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int                DEPTH       = 64,
  parameter logic [DATA_W-1:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int unsigned       WAIT_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
`ifdef MEM_STAGE_BOUNDS_CHK_EN
  output logic       mem_err,
`endif
  mem_stage_if.slave bus
);

  state_e            r_state;
  logic [CNT_W-1:0]  r_cnt;
  memwb_t            r_memwb;

  logic              w_req;
  logic              w_done;
  logic              w_in_range;
  logic [DATA_W-1:0] w_rdata;
  memwb_t            w_capture;

  assign w_req  = bus.MEM_R_EN | bus.MEM_W_EN;
  assign w_done = (r_state == BUSY) && (r_cnt == '0);

  // Nothing is accepted while reset is held, so no stall is raised then either.
  assign bus.freeze = rst && (((r_state == IDLE) && w_req) ||
                              ((r_state == BUSY) && (r_cnt != '0)));

  data_memory #(
    .DEPTH     (DEPTH),
    .BASE_ADDR (BASE_ADDR)
  ) u_dmem (
    .clk        (clk),
    .i_en       (w_done),
    .i_we       (bus.MEM_W_EN),
    .i_addr     (bus.ALU_Res),
    .i_wdata    (bus.Val_Rm),
    .o_rdata    (w_rdata),
    .o_in_range (w_in_range)
  );

  // Store wins over a simultaneous load, so load data only for a pure load.
  assign w_capture = '{
    wb_en:    bus.WB_EN,
    mem_r_en: bus.MEM_R_EN,
    alu_res:  bus.ALU_Res,
    mem_data: (w_done && bus.MEM_R_EN && !bus.MEM_W_EN) ? w_rdata : '0,
    dest:     bus.Dest
  };

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_memwb <= '0;
    end else if (r_state == IDLE) begin
      if (w_req) begin
        r_state <= BUSY;
        r_cnt   <= CNT_W'(WAIT_CYCLES);
        r_memwb <= '0;
      end else begin
        r_memwb <= w_capture;
      end
    end else if (r_cnt != '0) begin
      r_cnt   <= r_cnt - 1'b1;
      r_memwb <= '0;
    end else begin
      r_state <= IDLE;
      r_memwb <= w_capture;
    end
  end

`ifdef MEM_STAGE_BOUNDS_CHK_EN
  logic r_mem_err;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_mem_err <= 1'b0;
    end else if (w_done && (!w_in_range || (bus.ALU_Res[1:0] != 2'b00))) begin
      r_mem_err <= 1'b1;
    end
  end

  assign mem_err = r_mem_err;
`endif

  assign bus.WB_EN_out    = r_memwb.wb_en;
  assign bus.MEM_R_EN_out = r_memwb.mem_r_en;
  assign bus.ALU_Res_out  = r_memwb.alu_res;
  assign bus.Mem_Data_out = r_memwb.mem_data;
  assign bus.Dest_out     = r_memwb.dest;

endmodule
